// File: rtl/vector_muladd_v2.sv
// Pipelined CPF-lane multiply, adder-tree reduce, accumulate and requantise engine.
// Five register stages from input beat to op_dout/op_dout_en, independent of CPF.
module vector_muladd_v2 #(
    parameter int unsigned CPF       = 4,
    parameter int unsigned DIN_DW    = 16,
    parameter int unsigned WW        = 16,
    parameter int unsigned BIAS_DW   = 16,
    parameter int unsigned DOUT_DW   = 16,
    parameter int unsigned DIN_Q     = 6,
    parameter int unsigned Q         = 13,
    parameter int unsigned BIAS_Q    = 6,
    parameter int unsigned DOUT_Q    = 6,
    parameter int unsigned ACC_WIDTH = 40,
    parameter int unsigned RELU      = 1,
    parameter int unsigned ROUND     = 1,
    parameter int unsigned SAT       = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    op_din_en,
    input  logic                    op_din_eop,
    input  logic [CPF*DIN_DW-1:0]   op_din,
    input  logic [CPF*WW-1:0]       op_weight,
    input  logic [BIAS_DW-1:0]      op_bias,
    output logic [DOUT_DW-1:0]      op_dout,
    output logic                    op_dout_en
);

    localparam int unsigned PW   = DIN_DW + WW;
    localparam int unsigned FRAC = DIN_Q + Q;
    localparam int unsigned S    = FRAC - DOUT_Q;
    localparam int unsigned BSH  = FRAC - BIAS_Q;
    localparam int unsigned RW   = ACC_WIDTH + 1;

    localparam logic signed [RW-1:0] RND_C = (ROUND != 0) ? (RW'(1) <<< (S - 1)) : '0;
    localparam logic signed [RW-1:0] MAX_C = (RW'(1) <<< (DOUT_DW - 1)) - RW'(1);
    localparam logic signed [RW-1:0] MIN_C = -(RW'(1) <<< (DOUT_DW - 1));

    // S1: input capture
    logic                        s1_en, s1_eop;
    logic [CPF*DIN_DW-1:0]       s1_din;
    logic [CPF*WW-1:0]           s1_w;
    logic signed [BIAS_DW-1:0]   s1_bias;

    // S2: per-lane products
    logic                        s2_en, s2_eop;
    logic signed [PW-1:0]        s2_prod [CPF];
    logic signed [PW-1:0]        prod_c  [CPF];
    logic signed [BIAS_DW-1:0]   s2_bias;

    // S3: reduced sum
    logic                        s3_en, s3_eop;
    logic signed [ACC_WIDTH-1:0] s3_sum, sum_c;
    logic signed [BIAS_DW-1:0]   s3_bias;

    // S4: accumulator and pre-quantisation result
    logic                        first;
    logic signed [ACC_WIDTH-1:0] acc, acc_next, bias_al;
    logic                        pre_vld;
    logic signed [ACC_WIDTH-1:0] pre;

    // S5 requantisation datapath
    logic signed [RW-1:0]        r_rnd, r_sh;
    logic signed [DOUT_DW-1:0]   q_c;

    always_comb begin
        for (int unsigned i = 0; i < CPF; i++) begin
            prod_c[i] = PW'($signed(s1_din[i*DIN_DW +: DIN_DW]))
                      * PW'($signed(s1_w[i*WW +: WW]));
        end
    end

    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < CPF; i++) begin
            sum_c = sum_c + ACC_WIDTH'(s2_prod[i]);
        end
    end

    always_comb begin
        acc_next = (first ? '0 : acc) + s3_sum;
        bias_al  = ACC_WIDTH'(s3_bias) <<< BSH;
    end

    // Round, shift, then saturate or wrap, then optional ReLU
    always_comb begin
        r_rnd = RW'(pre) + RND_C;
        r_sh  = r_rnd >>> S;
        q_c   = DOUT_DW'(r_sh);
        if (SAT != 0) begin
            if (r_sh > MAX_C) begin
                q_c = DOUT_DW'(MAX_C);
            end else if (r_sh < MIN_C) begin
                q_c = DOUT_DW'(MIN_C);
            end
        end
        if (RELU != 0 && q_c[DOUT_DW-1]) begin
            q_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_en   <= 1'b0;
            s1_eop  <= 1'b0;
            s1_din  <= '0;
            s1_w    <= '0;
            s1_bias <= '0;
            s2_en   <= 1'b0;
            s2_eop  <= 1'b0;
            s2_bias <= '0;
            for (int unsigned i = 0; i < CPF; i++) begin
                s2_prod[i] <= '0;
            end
            s3_en   <= 1'b0;
            s3_eop  <= 1'b0;
            s3_sum  <= '0;
            s3_bias <= '0;
        end else begin
            s1_en   <= op_din_en;
            s1_eop  <= op_din_en & op_din_eop;
            s1_din  <= op_din;
            s1_w    <= op_weight;
            s1_bias <= $signed(op_bias);
            s2_en   <= s1_en;
            s2_eop  <= s1_eop;
            s2_bias <= s1_bias;
            for (int unsigned i = 0; i < CPF; i++) begin
                s2_prod[i] <= prod_c[i];
            end
            s3_en   <= s2_en;
            s3_eop  <= s2_eop;
            s3_sum  <= sum_c;
            s3_bias <= s2_bias;
        end
    end

    // Idle cycles leave acc/first untouched; an eop beat restarts the next vector from zero
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            first   <= 1'b1;
            pre_vld <= 1'b0;
            pre     <= '0;
        end else begin
            pre_vld <= s3_en & s3_eop;
            if (s3_en) begin
                if (s3_eop) begin
                    pre   <= acc_next + bias_al;
                    acc   <= '0;
                    first <= 1'b1;
                end else begin
                    acc   <= acc_next;
                    first <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_dout    <= '0;
            op_dout_en <= 1'b0;
        end else begin
            op_dout_en <= pre_vld;
            if (pre_vld) begin
                op_dout <= q_c;
            end
        end
    end

endmodule

// File: tb/tb_vector_muladd_v2.sv
// Bench for vector_muladd_v2: four configurations driven in parallel, checked
// against a whole-vector arithmetic model through per-instance expectation queues.
module tb_vector_muladd_v2;

    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, eop;
    logic [63:0] din, w;
    logic [15:0] bias;
    logic [15:0] dout_v [NI];
    logic [NI-1:0] en_v;

    int errors = 0;
    int checks = 0;
    int exp_q [NI][$];

    always #5 clk = ~clk;

    // cfg 0: RELU ROUND SAT; 1: ROUND SAT; 2: RELU SAT (truncate); 3: ROUND only (wrap)
    vector_muladd_v2 #(.RELU(1), .ROUND(1), .SAT(1)) dut0 (
        .clk(clk), .rst(rst), .op_din_en(en), .op_din_eop(eop), .op_din(din),
        .op_weight(w), .op_bias(bias), .op_dout(dout_v[0]), .op_dout_en(en_v[0]));
    vector_muladd_v2 #(.RELU(0), .ROUND(1), .SAT(1)) dut1 (
        .clk(clk), .rst(rst), .op_din_en(en), .op_din_eop(eop), .op_din(din),
        .op_weight(w), .op_bias(bias), .op_dout(dout_v[1]), .op_dout_en(en_v[1]));
    vector_muladd_v2 #(.RELU(1), .ROUND(0), .SAT(1)) dut2 (
        .clk(clk), .rst(rst), .op_din_en(en), .op_din_eop(eop), .op_din(din),
        .op_weight(w), .op_bias(bias), .op_dout(dout_v[2]), .op_dout_en(en_v[2]));
    vector_muladd_v2 #(.RELU(0), .ROUND(1), .SAT(0)) dut3 (
        .clk(clk), .rst(rst), .op_din_en(en), .op_din_eop(eop), .op_din(din),
        .op_weight(w), .op_bias(bias), .op_dout(dout_v[3]), .op_dout_en(en_v[3]));

    // Reference: exact vector dot product plus aligned bias, then requantise
    function automatic int model(input longint total, input int b, input int cfg);
        longint pre;
        bit relu, rnd, sat;
        relu = (cfg == 0 || cfg == 2);
        rnd  = (cfg != 2);
        sat  = (cfg != 3);
        pre = total + longint'(b) * 8192;
        pre = (pre <<< 24) >>> 24;
        if (rnd) pre = pre + 4096;
        pre = pre >>> 13;
        if (sat) begin
            if (pre > 32767) pre = 32767;
            if (pre < -32768) pre = -32768;
        end else begin
            pre = (pre <<< 48) >>> 48;
        end
        if (relu && pre < 0) pre = 0;
        return int'(pre);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                if (en_v[i]) begin
                    checks++;
                    if (exp_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL pulse_dut%0d: unexpected op_dout_en with op_dout=%0d, required no pulse",
                                 i, $signed(dout_v[i]));
                    end else begin
                        int e;
                        e = exp_q[i].pop_front();
                        if (int'($signed(dout_v[i])) != e) begin
                            errors++;
                            $display("FAIL result_dut%0d: op_dout=%0d, required %0d",
                                     i, $signed(dout_v[i]), e);
                        end
                    end
                end
            end
        end
    end

    task automatic push4(input int e0, input int e1, input int e2, input int e3);
        exp_q[0].push_back(e0);
        exp_q[1].push_back(e1);
        exp_q[2].push_back(e2);
        exp_q[3].push_back(e3);
    endtask

    task automatic beat(input logic p, input logic [63:0] d, input logic [63:0] ww,
                        input logic [15:0] b);
        en = 1'b1; eop = p; din = d; w = ww; bias = b;
        @(posedge clk); #1;
        en = 1'b0; eop = 1'b0;
    endtask

    task automatic idle(input int n);
        en = 1'b0; eop = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_drained(input string name);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                errors++;
                $display("FAIL %s_dut%0d: %0d results missing, required 0", name, i, exp_q[i].size());
                exp_q[i].delete();
            end
        end
    endtask

    task automatic check_dout(input string name, input int i, input int e);
        checks++;
        if (int'($signed(dout_v[i])) != e) begin
            errors++;
            $display("FAIL %s_dut%0d: op_dout=%0d, required %0d", name, i, $signed(dout_v[i]), e);
        end
    endtask

    typedef struct {
        string       name;
        int          nbeats;
        int          gap;
        logic [15:0] d;
        logic [15:0] wt;
        bit          lane0;
        logic [15:0] b;
        int          e [NI];
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [63:0] dd, wv;
        logic [15:0] rb;
        longint total;
        int nb;

        tbl[0] = '{"unit",     1, 0, 16'd64,    16'd8192,  1'b0, 16'd0,  '{256, 256, 256, 256}};
        tbl[1] = '{"gapbias",  3, 2, 16'd64,    16'd8192,  1'b0, 16'd64, '{832, 832, 832, 832}};
        tbl[2] = '{"neg",      1, 0, 16'd64,    16'hE000,  1'b0, 16'd0,  '{0, -256, 0, -256}};
        tbl[3] = '{"satpos",   8, 0, 16'd32767, 16'd32767, 1'b0, 16'd0,  '{32767, 32767, 32767, -256}};
        tbl[4] = '{"satneg",   8, 0, 16'd32767, 16'h8001,  1'b0, 16'd0,  '{0, -32768, 0, 256}};
        tbl[5] = '{"round",    1, 0, 16'd1,     16'd4096,  1'b1, 16'd0,  '{1, 1, 0, 1}};

        rst = 1'b1; en = 1'b0; eop = 1'b0; din = '0; w = '0; bias = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check_dout("reset_dout", i, 0);
            checks++;
            if (en_v[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_en_dut%0d: op_dout_en=%b, required 0", i, en_v[i]);
            end
        end
        rst = 1'b0;
        idle(2);

        // Directed table
        for (int t = 0; t < 6; t++) begin
            dd = tbl[t].lane0 ? {48'd0, tbl[t].d}  : {4{tbl[t].d}};
            wv = tbl[t].lane0 ? {48'd0, tbl[t].wt} : {4{tbl[t].wt}};
            push4(tbl[t].e[0], tbl[t].e[1], tbl[t].e[2], tbl[t].e[3]);
            for (int k = 0; k < tbl[t].nbeats; k++) begin
                beat(k == tbl[t].nbeats - 1, dd, wv, tbl[t].b);
                if (k < tbl[t].nbeats - 1) idle(tbl[t].gap);
            end
            idle(10);
            check_drained(tbl[t].name);
            for (int i = 0; i < NI; i++) check_dout({tbl[t].name, "_hold"}, i, tbl[t].e[i]);
        end

        // Latency: single-beat vector pulses exactly four edges after capture
        push4(256, 256, 256, 256);
        beat(1'b1, {4{16'd64}}, {4{16'd8192}}, 16'd0);
        for (int j = 0; j < 7; j++) begin
            checks++;
            if (en_v !== ((j == 4) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL latency_j%0d: op_dout_en=%b, required %b", j, en_v, (j == 4) ? 4'hF : 4'h0);
            end
            @(posedge clk); #1;
        end
        check_drained("latency");

        // Back-to-back vectors: A then B with no bubble, no carry from A
        push4(256, 256, 256, 256);
        push4(512, 512, 512, 512);
        beat(1'b1, {4{16'd64}},  {4{16'd8192}}, 16'd0);
        beat(1'b1, {4{16'd128}}, {4{16'd8192}}, 16'd0);
        for (int j = 0; j < 7; j++) begin
            checks++;
            if (en_v !== ((j == 3 || j == 4) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL b2b_j%0d: op_dout_en=%b, required %b", j, en_v,
                         (j == 3 || j == 4) ? 4'hF : 4'h0);
            end
            @(posedge clk); #1;
        end
        check_drained("b2b");

        // Reset with vector C in flight: no pulse, output cleared, next vector clean
        beat(1'b0, {4{16'd64}}, {4{16'd8192}}, 16'd0);
        beat(1'b1, {4{16'd64}}, {4{16'd8192}}, 16'd64);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(8);
        for (int i = 0; i < NI; i++) check_dout("midrst_dout", i, 0);
        push4(768, 768, 768, 768);
        for (int k = 0; k < 3; k++) beat(k == 2, {4{16'd64}}, {4{16'd8192}}, 16'd0);
        idle(8);
        check_drained("postrst");

        // Randomised vectors against the model
        for (int v = 0; v < 60; v++) begin
            logic [63:0] bd [4];
            logic [63:0] bw [4];
            nb = int'($urandom_range(1, 4));
            rb = 16'($signed(int'($urandom_range(0, 511)) - 256));
            total = 0;
            for (int k = 0; k < nb; k++) begin
                for (int l = 0; l < 4; l++) begin
                    int mg, dv, wq;
                    mg = int'($urandom_range(4, 15));
                    dv = int'($urandom_range(0, (1 << mg) - 1)) - (1 << (mg - 1));
                    mg = int'($urandom_range(4, 15));
                    wq = int'($urandom_range(0, (1 << mg) - 1)) - (1 << (mg - 1));
                    bd[k][l*16 +: 16] = 16'(dv);
                    bw[k][l*16 +: 16] = 16'(wq);
                    total += longint'(dv) * longint'(wq);
                end
            end
            push4(model(total, int'($signed(rb)), 0), model(total, int'($signed(rb)), 1),
                  model(total, int'($signed(rb)), 2), model(total, int'($signed(rb)), 3));
            for (int k = 0; k < nb; k++) begin
                beat(k == nb - 1, bd[k], bw[k], (k == nb - 1) ? rb : 16'h7FFF);
                if (k < nb - 1) idle(int'($urandom_range(0, 2)));
            end
            idle(int'($urandom_range(0, 1)));
        end
        idle(12);
        check_drained("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vector_muladd_v2.md
Name: vector_muladd_v2

Overview:
Parametrised successor to the conv-layer MAC engine. Each beat it takes CPF input channels and CPF weights, multiplies them lane by lane, reduces the products through a registered adder tree, and accumulates across beats until end-of-packet. At end-of-packet it adds the aligned bias, requantises with optional rounding, saturation and ReLU, and emits a result qualified by a valid strobe. It sits between the row-memory/weight-buffer read ports and the layer output in every convN_layer wrapper.

Parameters:
CPF, 4, input channels processed per beat (lanes), >=1
DIN_DW, 16, signed data width per lane
WW, 16, signed weight width per lane
BIAS_DW, 16, signed bias width
DOUT_DW, 16, signed output width
DIN_Q, 6, data fractional bits
Q, 13, weight fractional bits
BIAS_Q, 6, bias fractional bits; must be <= DIN_Q+Q
DOUT_Q, 6, output fractional bits; S = DIN_Q+Q-DOUT_Q must be >= 1
ACC_WIDTH, 40, accumulator width; must be >= DIN_DW+WW+clog2(CPF)
RELU, 1, 1 = clamp negative results to 0
ROUND, 1, 1 = round half up before the right shift; 0 = truncate
SAT, 1, 1 = saturate to DOUT_DW; 0 = keep the low DOUT_DW bits

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
op_din_en  in  1  beat valid
op_din_eop  in  1  last beat of vector; ignored unless op_din_en=1
op_din  in  CPF*DIN_DW  lane i at bits [i*DIN_DW +: DIN_DW]
op_weight  in  CPF*WW  lane i at bits [i*WW +: WW]
op_bias  in  BIAS_DW  sampled on the eop beat
op_dout  out  DOUT_DW  result; holds until the next result
op_dout_en  out  1  one-cycle pulse when op_dout updates

Behaviour:
- Single clock. Reset is synchronous and active-high.
- Reset: op_dout=0, op_dout_en=0, accumulator=0, all stage valids=0. A reset in mid-vector discards the partial vector; no result is emitted for it.
- Pipeline, for an input beat registered at edge T:
  - S1 (T+1): register data, weights, en, eop and bias.
  - S2 (T+2): CPF signed products, each DIN_DW+WW bits with DIN_Q+Q fractional bits.
  - S3 (T+3): sign-extend the products to ACC_WIDTH and sum them in a single registered stage.
  - S4 (T+4): accumulate. acc_next = (first ? 0 : acc) + sum. On an eop beat, pre = acc_next + (sign-extended bias << (DIN_Q+Q-BIAS_Q)), and acc clears.
  - S5 (T+5): requantise, update op_dout, pulse op_dout_en.
- Latency: eop beat at T -> op_dout_en=1 during cycle T+5. The latency is fixed for all CPF.
- first: set after reset and after every eop beat; cleared by any non-eop valid beat.
- Gaps: cycles with op_din_en=0 leave acc and first unchanged. Any number of idle cycles may separate beats.
- Single-beat vector: en=1 and eop=1 on the same beat give result = sum + bias.
- Back-to-back vectors: eop at T and a new beat at T+1 is legal. The new vector starts from 0 with no bubble.
- Throughput: one beat per cycle, with no backpressure.
- Requantise, applied to pre in this order:
  - If ROUND=1, add 1<<(S-1).
  - Arithmetic shift right by S.
  - If SAT=1, clamp to [-2^(DOUT_DW-1), 2^(DOUT_DW-1)-1].
  - If RELU=1, negative -> 0.
- Accumulator overflow beyond ACC_WIDTH wraps. Sizing ACC_WIDTH is the integrator's responsibility.
- op_dout_en is never asserted for a vector that has no eop beat.

Test Plan:
1. CPF=4. One beat with en=eop=1, all din=64 (1.0), all weights=8192 (1.0), bias=0 at T -> op_dout=256, op_dout_en high only at T+5.
2. Three beats with the same data, separated by 2 idle cycles each; bias=64 on the eop beat -> exactly one pulse, op_dout=832; op_dout holds 832 afterward.
3. RELU=1 with weights=-8192 in scenario 1 -> op_dout=0. RELU=0 with the same stimulus -> op_dout=-256 (0xFF00).
4. SAT=1, RELU=0, din=32767, weights=32767, 8 beats -> 32767; negating the weights -> -32768.
5. Lane 0 din=1 and weight=4096, other lanes 0, bias 0 -> ROUND=1 gives 1, ROUND=0 gives 0.
6. Vector A (result 256) with eop at T, vector B (result 512) starting at T+1 -> pulses at T+5 and T+6 with no carry from A into B. Then assert rst for 1 cycle in the middle of a vector C -> no pulse for C, op_dout=0, and the next vector produces the correct result.
